// File: rtl/sequenciador_medidas_n_if.sv
// Character link between the measurement sequencer and its external 7E1
// transmitter/receiver pair.
interface sequenciador_medidas_n_if;
  logic       tx_partida;
  logic [6:0] tx_dado;
  logic       tx_pronto;
  logic       rx_pronto;
  logic [6:0] rx_dado;

  modport master (
    output tx_partida,
    output tx_dado,
    input  tx_pronto,
    input  rx_pronto,
    input  rx_dado
  );

  modport slave (
    input  tx_partida,
    input  tx_dado,
    output tx_pronto,
    output rx_pronto,
    output rx_dado
  );
endinterface

// File: rtl/sequenciador_medidas_n.sv
// Serialises N_CH BCD measurements as ASCII frames over a char-at-a-time
// transmitter and collects received chars into N_RX registers.
module sequenciador_medidas_n #(
  parameter int         N_CH   = 3,
  parameter int         DIGITS = 3,
  parameter logic [6:0] SEP    = 7'h23,
  parameter bit         EOL_EN = 1'b1,
  parameter logic [6:0] EOL    = 7'h0A,
  parameter int         N_RX   = 3,
  parameter logic [6:0] SYNC   = 7'h0D
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [N_CH*4*DIGITS-1:0]   medidas,
  sequenciador_medidas_n_if.master   link,
  output logic                       ocupado,
  output logic                       fim_quadro,
  output logic [N_RX*7-1:0]          dados_rx,
  output logic [$clog2(N_RX)-1:0]    rx_indice,
  output logic                       rx_completo,
  output logic [3:0]                 db_estado
);

  localparam int CH_W  = $clog2(N_CH + 1);
  localparam int POS_W = $clog2(DIGITS + 1);
  localparam int IDX_W = $clog2(N_RX);
  // Position of the final char: the EOL slot, or the last channel's separator.
  localparam logic [CH_W-1:0]  LAST_CH  = EOL_EN ? CH_W'(N_CH) : CH_W'(N_CH - 1);
  localparam logic [POS_W-1:0] LAST_POS = EOL_EN ? POS_W'(0) : POS_W'(DIGITS);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CAPTURA = 4'd1,
    ENVIA   = 4'd2,
    ESPERA  = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  estado_t                   estado_q;
  logic [N_CH*4*DIGITS-1:0]  snap_q;
  logic [CH_W-1:0]           ch_q;
  logic [POS_W-1:0]          pos_q;
  logic                      tx_partida_q;
  logic [6:0]                tx_dado_q;
  logic                      ocupado_q;
  logic                      fim_q;

  logic [CH_W-1:0]           nxt_ch_s;
  logic [POS_W-1:0]          nxt_pos_s;
  logic [CH_W-1:0]           sel_ch_s;
  logic [POS_W-1:0]          sel_pos_s;
  logic [3:0]                nibble_s;
  logic [6:0]                char_s;
  logic                      ultimo_s;

  logic [N_RX*7-1:0]         dados_rx_q, dados_rx_d;
  logic [IDX_W-1:0]          rx_indice_q, rx_indice_d;
  logic                      rx_completo_q, rx_completo_d;

  function automatic logic [6:0] ascii_digito(input logic [3:0] n);
    return (n <= 4'd9) ? {3'b011, n} : 7'h3F;
  endfunction

  // Pointer (channel, position-within-channel) of the char following the current one.
  always_comb begin
    if (pos_q == POS_W'(DIGITS)) begin
      nxt_ch_s  = ch_q + 1'b1;
      nxt_pos_s = '0;
    end else begin
      nxt_ch_s  = ch_q;
      nxt_pos_s = pos_q + 1'b1;
    end
  end

  assign sel_ch_s  = (estado_q == PROXIMO) ? nxt_ch_s  : ch_q;
  assign sel_pos_s = (estado_q == PROXIMO) ? nxt_pos_s : pos_q;
  assign ultimo_s  = (ch_q == LAST_CH) && (pos_q == LAST_POS);

  // ASCII char at the selected pointer; position 0 is the most significant digit.
  always_comb begin
    nibble_s = 4'd0;
    for (int c = 0; c < N_CH; c++) begin
      for (int d = 0; d < DIGITS; d++) begin
        nibble_s = (sel_ch_s == CH_W'(c) && sel_pos_s == POS_W'(DIGITS - 1 - d)) ?
                   snap_q[(c*DIGITS + d)*4 +: 4] : nibble_s;
      end
    end
    if (sel_ch_s >= CH_W'(N_CH)) begin
      char_s = EOL;
    end else if (sel_pos_s == POS_W'(DIGITS)) begin
      char_s = SEP;
    end else begin
      char_s = ascii_digito(nibble_s);
    end
  end

  // Transmit FSM with registered handshake and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      snap_q       <= '0;
      ch_q         <= '0;
      pos_q        <= '0;
      tx_partida_q <= 1'b0;
      tx_dado_q    <= 7'd0;
      ocupado_q    <= 1'b0;
      fim_q        <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            estado_q  <= CAPTURA;
            snap_q    <= medidas;
            ch_q      <= '0;
            pos_q     <= '0;
            ocupado_q <= 1'b1;
          end
        end
        CAPTURA: begin
          estado_q     <= ENVIA;
          tx_partida_q <= 1'b1;
          tx_dado_q    <= char_s;
        end
        ENVIA: begin
          estado_q     <= ESPERA;
          tx_partida_q <= 1'b0;
        end
        ESPERA: begin
          if (link.tx_pronto) begin
            estado_q <= ultimo_s ? FIM : PROXIMO;
            fim_q    <= ultimo_s;
          end
        end
        PROXIMO: begin
          estado_q     <= ENVIA;
          ch_q         <= nxt_ch_s;
          pos_q        <= nxt_pos_s;
          tx_partida_q <= 1'b1;
          tx_dado_q    <= char_s;
        end
        FIM: begin
          estado_q  <= OCIOSO;
          fim_q     <= 1'b0;
          ocupado_q <= 1'b0;
        end
        default: begin
          estado_q     <= OCIOSO;
          tx_partida_q <= 1'b0;
          fim_q        <= 1'b0;
          ocupado_q    <= 1'b0;
        end
      endcase
    end
  end

  // Receive path: SYNC realigns to register 0 without writing anything.
  always_comb begin
    dados_rx_d    = dados_rx_q;
    rx_indice_d   = rx_indice_q;
    rx_completo_d = 1'b0;
    if (link.rx_pronto) begin
      if (link.rx_dado == SYNC) begin
        rx_indice_d = '0;
      end else begin
        for (int r = 0; r < N_RX; r++) begin
          dados_rx_d[r*7 +: 7] = (rx_indice_q == IDX_W'(r)) ? link.rx_dado : dados_rx_q[r*7 +: 7];
        end
        if (rx_indice_q == IDX_W'(N_RX - 1)) begin
          rx_indice_d   = '0;
          rx_completo_d = 1'b1;
        end else begin
          rx_indice_d = rx_indice_q + 1'b1;
        end
      end
    end else begin
      rx_completo_d = 1'b0;
    end
  end

  // Receive registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      dados_rx_q    <= '0;
      rx_indice_q   <= '0;
      rx_completo_q <= 1'b0;
    end else begin
      dados_rx_q    <= dados_rx_d;
      rx_indice_q   <= rx_indice_d;
      rx_completo_q <= rx_completo_d;
    end
  end

  assign link.tx_partida = tx_partida_q;
  assign link.tx_dado    = tx_dado_q;
  assign ocupado         = ocupado_q;
  assign fim_quadro      = fim_q;
  assign dados_rx        = dados_rx_q;
  assign rx_indice       = rx_indice_q;
  assign rx_completo     = rx_completo_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_sequenciador_medidas_n.sv
// Bench for sequenciador_medidas_n: default instance plus a 1-channel, 4-digit, no-EOL instance.
module tb_sequenciador_medidas_n;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sequenciador_medidas_n_if ifa();
  sequenciador_medidas_n_if ifb();

  logic        iniciar_a, ocupado_a, fim_a, rx_completo_a;
  logic [35:0] medidas_a;
  logic [20:0] dados_rx_a;
  logic [1:0]  rx_indice_a;
  logic [3:0]  db_estado_a;

  logic        iniciar_b, ocupado_b, fim_b, rx_completo_b;
  logic [15:0] medidas_b;
  logic [20:0] dados_rx_b;
  logic [1:0]  rx_indice_b;
  logic [3:0]  db_estado_b;

  sequenciador_medidas_n dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar_a), .medidas(medidas_a), .link(ifa),
    .ocupado(ocupado_a), .fim_quadro(fim_a), .dados_rx(dados_rx_a), .rx_indice(rx_indice_a),
    .rx_completo(rx_completo_a), .db_estado(db_estado_a)
  );

  sequenciador_medidas_n #(.N_CH(1), .DIGITS(4), .EOL_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar_b), .medidas(medidas_b), .link(ifb),
    .ocupado(ocupado_b), .fim_quadro(fim_b), .dados_rx(dados_rx_b), .rx_indice(rx_indice_b),
    .rx_completo(rx_completo_b), .db_estado(db_estado_b)
  );

  int tests = 0;
  int fails = 0;
  int part_cnt [2];
  int fim_cnt [2];
  int rxc_cnt = 0;
  logic [6:0] exp_q [$];
  logic [6:0] mreg [3];
  int midx = 0;

  // Event counters, sampled on the falling edge.
  always @(negedge clock) begin
    if (ifa.tx_partida === 1'b1) part_cnt[0]++;
    if (ifb.tx_partida === 1'b1) part_cnt[1]++;
    if (fim_a === 1'b1) fim_cnt[0]++;
    if (fim_b === 1'b1) fim_cnt[1]++;
    if (rx_completo_a === 1'b1) rxc_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic partida(input bit s);
    return s ? ifb.tx_partida : ifa.tx_partida;
  endfunction
  function automatic logic [6:0] dado(input bit s);
    return s ? ifb.tx_dado : ifa.tx_dado;
  endfunction
  function automatic logic ocup(input bit s);
    return s ? ocupado_b : ocupado_a;
  endfunction
  function automatic logic fim(input bit s);
    return s ? fim_b : fim_a;
  endfunction

  task automatic set_ini(input bit s, input logic v);
    if (s) iniciar_b = v; else iniciar_a = v;
  endtask
  task automatic set_pronto(input bit s, input logic v);
    if (s) ifb.tx_pronto = v; else ifa.tx_pronto = v;
  endtask
  task automatic set_med(input bit s, input logic [63:0] m);
    if (s) medidas_b = m[15:0]; else medidas_a = m[35:0];
  endtask

  // Expected frame from the char-order rules: channels ascending, MS digit first.
  task automatic build(input logic [63:0] med, input int nch, input int dig, input bit eol_en);
    int nib;
    exp_q.delete();
    for (int c = 0; c < nch; c++) begin
      for (int d = dig - 1; d >= 0; d--) begin
        nib = int'((med >> (4 * (c * dig + d))) & 64'hF);
        exp_q.push_back(nib < 10 ? 7'(8'h30 + nib) : 7'h3F);
      end
      exp_q.push_back(7'h23);
    end
    if (eol_en) exp_q.push_back(7'h0A);
  endtask

  function automatic logic [63:0] rand_med(input int nibbles);
    logic [63:0] m = '0;
    for (int i = 0; i < nibbles; i++) m[i*4 +: 4] = 4'($urandom_range(0, 11));
    return m;
  endfunction

  task automatic run_frame(input bit s, input logic [63:0] med, input bit disturb, input int abort_at);
    int p0, f0;
    logic [6:0] held;
    if (s) build(med, 1, 4, 1'b0); else build(med, 3, 3, 1'b1);
    p0 = part_cnt[s];
    f0 = fim_cnt[s];
    set_med(s, med);
    set_ini(s, 1'b1);
    tick;
    set_ini(s, 1'b0);
    set_med(s, {$urandom, $urandom});
    if (!s) chk("state_captura", db_estado_a, 4'd1);
    tick;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("partida_%0d", i), partida(s), 1'b1);
      chk($sformatf("char_%0d", i), dado(s), exp_q[i]);
      if (!s) chk("state_envia", db_estado_a, 4'd2);
      held = dado(s);
      if (disturb) begin
        set_pronto(s, 1'b1);
        set_ini(s, 1'b1);
        tick;
        set_pronto(s, 1'b0);
        set_ini(s, 1'b0);
      end
      repeat ($urandom_range(1, 3)) tick;
      chk("hold_dado", dado(s), held);
      chk("busy", ocup(s), 1'b1);
      if (!s) chk("state_espera", db_estado_a, 4'd3);
      set_pronto(s, 1'b1);
      tick;
      set_pronto(s, 1'b0);
      if (i + 1 == abort_at) return;
      if (i == exp_q.size() - 1) begin
        chk("fim_pulse", fim(s), 1'b1);
        tick;
        chk("fim_low", fim(s), 1'b0);
        chk("idle_after", ocup(s), 1'b0);
      end else begin
        tick;
      end
    end
    chk("partida_count", part_cnt[s] - p0, exp_q.size());
    chk("fim_count", fim_cnt[s] - f0, 1);
  endtask

  task automatic rx_send(input logic [6:0] c);
    bit wrap = 1'b0;
    ifa.rx_dado = c;
    ifa.rx_pronto = 1'b1;
    tick;
    ifa.rx_pronto = 1'b0;
    if (c == 7'h0D) begin
      midx = 0;
    end else begin
      mreg[midx] = c;
      if (midx == 2) begin
        midx = 0;
        wrap = 1'b1;
      end else begin
        midx++;
      end
    end
    chk("rx_completo", rx_completo_a, wrap);
    chk("rx_indice", rx_indice_a, midx);
    chk("dados_rx", dados_rx_a, {mreg[2], mreg[1], mreg[0]});
  endtask

  initial begin
    int p_ab, f_ab, rxc0;
    reset = 1'b1;
    iniciar_a = 1'b0; iniciar_b = 1'b0; medidas_a = '0; medidas_b = '0;
    ifa.tx_pronto = 1'b0; ifa.rx_pronto = 1'b0; ifa.rx_dado = 7'd0;
    ifb.tx_pronto = 1'b0; ifb.rx_pronto = 1'b0; ifb.rx_dado = 7'd0;
    mreg[0] = 7'd0; mreg[1] = 7'd0; mreg[2] = 7'd0;
    tick;
    tick;
    chk("rst_partida", ifa.tx_partida, 1'b0);
    chk("rst_dado", ifa.tx_dado, 7'd0);
    chk("rst_ocupado", ocupado_a, 1'b0);
    chk("rst_fim", fim_a, 1'b0);
    chk("rst_estado", db_estado_a, 4'd0);
    chk("rst_dados_rx", dados_rx_a, 21'd0);
    chk("rst_rx_indice", rx_indice_a, 2'd0);
    chk("rst_rx_completo", rx_completo_a, 1'b0);
    reset = 1'b0;
    tick;

    run_frame(1'b0, 64'h9990_4512_3, 1'b0, 0);
    run_frame(1'b0, 64'h9990_451A_3, 1'b0, 0);

    run_frame(1'b0, rand_med(9), 1'b1, 0);
    p_ab = part_cnt[0];
    set_pronto(1'b0, 1'b1);
    tick;
    set_pronto(1'b0, 1'b0);
    repeat (4) tick;
    chk("idle_pronto_no_partida", part_cnt[0] - p_ab, 0);
    chk("idle_pronto_state", db_estado_a, 4'd0);

    for (int k = 0; k < 3; k++) run_frame(1'b0, rand_med(9), 1'b0, 0);

    run_frame(1'b0, rand_med(9), 1'b0, 5);
    reset = 1'b1;
    iniciar_a = 1'b1; ifa.tx_pronto = 1'b1; ifa.rx_pronto = 1'b1; ifa.rx_dado = 7'h5A;
    tick;
    p_ab = part_cnt[0];
    f_ab = fim_cnt[0];
    chk("abort_ocupado", ocupado_a, 1'b0);
    chk("abort_estado", db_estado_a, 4'd0);
    chk("abort_partida", ifa.tx_partida, 1'b0);
    chk("abort_dados_rx", dados_rx_a, 21'd0);
    chk("abort_rx_indice", rx_indice_a, 2'd0);
    reset = 1'b0;
    iniciar_a = 1'b0; ifa.tx_pronto = 1'b0; ifa.rx_pronto = 1'b0;
    tick;
    chk("rst_ignores_iniciar", ocupado_a, 1'b0);
    repeat (10) tick;
    chk("abort_no_partida", part_cnt[0] - p_ab, 0);
    chk("abort_no_fim", fim_cnt[0] - f_ab, 0);
    run_frame(1'b0, 64'h9990_4512_3, 1'b0, 0);

    rxc0 = rxc_cnt;
    rx_send(7'h41);
    rx_send(7'h42);
    rx_send(7'h43);
    tick;
    chk("rx_completo_once", rxc_cnt - rxc0, 1);
    chk("rx_reg0", dados_rx_a[6:0], 7'h41);
    chk("rx_reg2", dados_rx_a[20:14], 7'h43);
    rx_send(7'h44);
    rx_send(7'h0D);
    rx_send(7'h45);
    chk("rx_reg0_after_sync", dados_rx_a[6:0], 7'h45);
    chk("rx_reg1_kept", dados_rx_a[13:7], 7'h42);
    for (int k = 0; k < 24; k++) begin
      rx_send(($urandom_range(0, 3) == 0) ? 7'h0D : 7'($urandom_range(0, 127)));
    end

    run_frame(1'b1, 64'h0789, 1'b0, 0);
    run_frame(1'b1, rand_med(4), 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
